pc_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC register, issues fetches to instruction memory over a req/ready

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 30 +++
 rtl/pc_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT   = 16'h0000;
    localparam logic [3:0]      HLT_OPCODE_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DROP,
        ST_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] pc_plus2;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its pc+2
// while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output logic         full,
    output fetch_entry_t entry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ready handshake, IF/ID
// register with a one-entry skid buffer, branch redirect and HLT.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [3:0]      HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] current_pc,
    output logic            if_id_valid,
    output logic [PC_W-1:0] if_id_instr,
    output logic [PC_W-1:0] if_id_pc_plus2,
    output logic            halted
);

    fetch_state_e    state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [PC_W-1:0] drop_pc, drop_pc_n;
    logic            if_id_valid_n;
    logic [PC_W-1:0] if_id_instr_n;
    logic [PC_W-1:0] if_id_pc_plus2_n;

    logic            skid_load, skid_drain, skid_clear, skid_full;
    fetch_entry_t    skid_entry, skid_in;

    logic            req_raw;
    logic            outstanding;
    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] redirect_target;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_entry (skid_in),
        .full       (skid_full),
        .entry      (skid_entry)
    );

    assign current_pc = pc;
    assign imem_addr  = pc;
    assign imem_req   = req_raw & ~rst;
    assign halted     = (state == ST_HALTED);

    assign pc_plus2        = pc_inc(pc);
    assign redirect_target = redirect_pc & ~16'h0001;
    assign skid_in         = '{instr: imem_rdata, pc_plus2: pc_plus2};

    always_comb begin
        req_raw = 1'b0;
        case (state)
            ST_RUN:            req_raw = ~skid_full;
            ST_WAIT, ST_DROP:  req_raw = 1'b1;
            default:           req_raw = 1'b0;
        endcase
    end

    assign outstanding = req_raw & ~imem_ready;

    always_comb begin
        state_n          = state;
        pc_n             = pc;
        drop_pc_n        = drop_pc;
        if_id_valid_n    = if_id_valid;
        if_id_instr_n    = if_id_instr;
        if_id_pc_plus2_n = if_id_pc_plus2;
        skid_load        = 1'b0;
        skid_drain       = 1'b0;
        skid_clear       = 1'b0;

        if (redirect_valid) begin
            // A completing access (ready this cycle) is simply discarded;
            // only a still-pending one has to be drained through DROP.
            if_id_valid_n = 1'b0;
            skid_clear    = 1'b1;
            if (outstanding) begin
                state_n   = ST_DROP;
                drop_pc_n = redirect_target;
            end else begin
                state_n = ST_RUN;
                pc_n    = redirect_target;
            end
        end else begin
            case (state)
                ST_RUN, ST_WAIT: begin
                    if (skid_full) begin
                        if (!stall) begin
                            if_id_valid_n    = 1'b1;
                            if_id_instr_n    = skid_entry.instr;
                            if_id_pc_plus2_n = skid_entry.pc_plus2;
                            skid_drain       = 1'b1;
                            state_n = (skid_entry.instr[15:12] == HLT_OPCODE) ? ST_HALTED : ST_RUN;
                        end
                    end else if (imem_ready) begin
                        pc_n = pc_plus2;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_n   = ST_RUN;
                        end else begin
                            if_id_valid_n    = 1'b1;
                            if_id_instr_n    = imem_rdata;
                            if_id_pc_plus2_n = pc_plus2;
                            state_n = (imem_rdata[15:12] == HLT_OPCODE) ? ST_HALTED : ST_RUN;
                        end
                    end else begin
                        state_n = ST_WAIT;
                        if (!stall) begin
                            if_id_valid_n = 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if_id_valid_n = 1'b0;
                    if (imem_ready) begin
                        pc_n    = drop_pc;
                        state_n = ST_RUN;
                    end
                end
                default: begin
                    if (!stall) begin
                        if_id_valid_n = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            pc             <= RESET_PC;
            drop_pc        <= '0;
            if_id_valid    <= 1'b0;
            if_id_instr    <= '0;
            if_id_pc_plus2 <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            drop_pc        <= drop_pc_n;
            if_id_valid    <= if_id_valid_n;
            if_id_instr    <= if_id_instr_n;
            if_id_pc_plus2 <= if_id_pc_plus2_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: scoreboard of IF/ID deliveries plus
// cycle checks of the memory interface, PC and halt state.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] current_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        halted;

    pc_fetch_stage #(
        .RESET_PC   (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .current_pc     (current_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ready once the request has been held mem_lat cycles.
    logic mem_block;
    int   mem_lat;
    int   wcnt;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0002: return 16'h2222;
            16'h0010: return 16'h5A10;
            16'h0012: return 16'hABCD;
            16'h0020: return 16'hF000;
            16'h0030: return 16'h3330;
            16'hFFFE: return 16'h7FFE;
            default:  return {4'h0, a[12:1]};
        endcase
    endfunction

    always_comb begin
        imem_ready = imem_req && !mem_block && (wcnt >= mem_lat);
        imem_rdata = mem_data(imem_addr);
    end

    always @(posedge clk) begin
        if (imem_req && !imem_ready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Decode consumes IF/ID whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst && if_id_valid && !stall) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL if_id_unexpected: got instr %h pc_plus2 %h expected none",
                         if_id_instr, if_id_pc_plus2);
            end else begin
                mon_e = sb.pop_front();
                check("if_id_instr", if_id_instr, mon_e.instr);
                check("if_id_pc_plus2", if_id_pc_plus2, mon_e.pc_plus2);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Precondition: an access is pending with memory blocked. Redirect goes
    // through DROP, the old access completes and is discarded.
    task automatic redirect_via_drop(input logic [15:0] target, input logic [15:0] old_addr);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drop_req", {15'd0, imem_req}, 16'd1);
        check("drop_addr", imem_addr, old_addr);
        check("drop_valid", {15'd0, if_id_valid}, 16'd0);
        mem_lat   = 0;
        mem_block = 1'b0;
        tick();
        #1;
        check("drop_exit_pc", current_pc, target & 16'hFFFE);
        check("drop_exit_addr", imem_addr, target & 16'hFFFE);
        check("drop_exit_valid", {15'd0, if_id_valid}, 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_block      = 1'b0;
        mem_lat        = 0;

        // 1: reset state, then zero-wait fetches at 0 and 2
        tick();
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_pc", current_pc, 16'h0000);
        check("rst_valid", {15'd0, if_id_valid}, 16'd0);
        check("rst_instr", if_id_instr, 16'h0000);
        check("rst_pc_plus2", if_id_pc_plus2, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'd0);
        tick();
        rst = 1'b0;
        sb.push_back('{instr: 16'h1111, pc_plus2: 16'h0002});
        sb.push_back('{instr: 16'h2222, pc_plus2: 16'h0004});
        #1;
        check("t1_req", {15'd0, imem_req}, 16'd1);
        check("t1_addr0", imem_addr, 16'h0000);
        tick();
        check("t1_addr2", imem_addr, 16'h0002);
        tick();
        mem_block = 1'b1;
        check("t1_pc4", current_pc, 16'h0004);
        tick();

        // 2: reach 0x10 via redirect, then three wait cycles
        redirect_via_drop(16'h0011, 16'h0004);
        mem_lat = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_bubble", {15'd0, if_id_valid}, 16'd0);
            check("t2_addr_stable", imem_addr, 16'h0010);
        end
        sb.push_back('{instr: 16'h5A10, pc_plus2: 16'h0012});
        tick();
        check("t2_pc", current_pc, 16'h0012);

        // 3: stall while 0xABCD returns -> skid, then drain
        stall   = 1'b1;
        mem_lat = 0;
        tick();
        check("t3_no_req", {15'd0, imem_req}, 16'd0);
        check("t3_pc", current_pc, 16'h0014);
        check("t3_hold", if_id_instr, 16'h5A10);
        tick();
        check("t3_no_req2", {15'd0, imem_req}, 16'd0);
        stall = 1'b0;
        sb.push_back('{instr: 16'hABCD, pc_plus2: 16'h0014});
        #1;
        check("t3_drain_no_req", {15'd0, imem_req}, 16'd0);
        tick();
        check("t3_resume_req", {15'd0, imem_req}, 16'd1);
        check("t3_resume_addr", imem_addr, 16'h0014);
        mem_block = 1'b1;
        tick();

        // 4: redirect to 0x0041 during WAIT
        redirect_via_drop(16'h0041, 16'h0014);
        mem_block = 1'b1;
        tick();
        check("t4_no_stray", {15'd0, if_id_valid}, 16'd0);

        // 5: HLT at 0x20, then redirect to 0x30
        redirect_via_drop(16'h0020, 16'h0040);
        sb.push_back('{instr: 16'hF000, pc_plus2: 16'h0022});
        tick();
        check("t5_halted", {15'd0, halted}, 16'd1);
        check("t5_req", {15'd0, imem_req}, 16'd0);
        check("t5_pc", current_pc, 16'h0022);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_halted", {15'd0, halted}, 16'd1);
            check("t5_hold_req", {15'd0, imem_req}, 16'd0);
            check("t5_hold_pc", current_pc, 16'h0022);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0030;
        tick();
        redirect_valid = 1'b0;
        sb.push_back('{instr: 16'h3330, pc_plus2: 16'h0032});
        #1;
        check("t5_unhalt", {15'd0, halted}, 16'd0);
        check("t5_req_30", {15'd0, imem_req}, 16'd1);
        check("t5_addr_30", imem_addr, 16'h0030);
        tick();
        check("t5_pc_32", current_pc, 16'h0032);
        mem_block = 1'b1;
        tick();

        // 6: wrap at 0xFFFE, then reset in the middle of WAIT
        redirect_via_drop(16'hFFFE, 16'h0032);
        sb.push_back('{instr: 16'h7FFE, pc_plus2: 16'h0000});
        sb.push_back('{instr: 16'h1111, pc_plus2: 16'h0002});
        tick();
        check("t6_wrap_addr", imem_addr, 16'h0000);
        check("t6_wrap_pc", current_pc, 16'h0000);
        tick();
        check("t6_pc2", current_pc, 16'h0002);
        mem_block = 1'b1;
        tick();
        check("t6_wait_addr", imem_addr, 16'h0002);
        rst = 1'b1;
        #1;
        check("t6_rst_req", {15'd0, imem_req}, 16'd0);
        tick();
        check("t6_rst_pc", current_pc, 16'h0000);
        check("t6_rst_valid", {15'd0, if_id_valid}, 16'd0);
        check("t6_rst_halted", {15'd0, halted}, 16'd0);
        tick();
        check("sb_drained", sb.size(), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
